el2_bp_ghr_ctrl: RTL
====================

Name: el2_bp_ghr_ctrl

Overview:
- Owns the branch-predictor global history register (GHR) that feeds the BHT/GHR index hash.
- Keeps two histories:
  - fghr: speculative, shifted at fetch on every predicted branch.
  - rghr: retired, shifted at branch resolution.
- A small in-order checkpoint FIFO holds the predicted direction of each in-flight branch.
- On a mispredict or flush, fghr is restored from rghr plus the actual outcome.

Parameters:
- GHR_SIZE, 8, history width in bits; must be >= 2.
- CKPT_DEPTH, 4, number of in-flight predicted branches tracked; power of 2, >= 2.
- CKPT_PTR_W, $clog2(CKPT_DEPTH), FIFO pointer width (derived; not overridden).

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- ifu_bp_valid  input  1  fetch presents a predicted branch this cycle
- ifu_bp_taken  input  1  predicted direction of that branch
- exu_br_valid  input  1  oldest in-flight branch resolves this cycle
- exu_br_taken  input  1  actual direction of resolving branch
- exu_br_tgt_mp  input  1  resolving branch had a target mispredict (direction may be correct)
- exu_flush  input  1  non-branch pipeline flush (exception/interrupt)
- fghr  output  GHR_SIZE  speculative history to the GHR hash
- rghr  output  GHR_SIZE  retired history
- ghr_ckpt_full  output  1  FIFO full; fetch must stall prediction
- ghr_ckpt_empty  output  1  no branch in flight
- ghr_mispredict  output  1  registered one-cycle pulse; a direction or target mispredict was resolved last cycle
- ghr_err  output  1  registered pulse; exu_br_valid arrived with FIFO empty

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - fghr = 0, rghr = 0.
  - Pointers and count = 0; ghr_ckpt_empty = 1, ghr_ckpt_full = 0.
  - ghr_mispredict = 0, ghr_err = 0.
  - Reset asserted mid-operation discards all in-flight entries immediately.
- Push: push_en = ifu_bp_valid & ~ghr_ckpt_full & ~recover.
  - ckpt[wptr] <= ifu_bp_taken; wptr++ (wraps modulo CKPT_DEPTH).
  - fghr <= {fghr[GHR_SIZE-2:0], ifu_bp_taken}.
  - No acceptance when full, even if a resolve frees an entry in the same cycle; fetch retries next cycle.
- Resolve: pop_en = exu_br_valid & ~ghr_ckpt_empty.
  - Pops ckpt[rptr]; rptr++.
  - rghr <= {rghr[GHR_SIZE-2:0], exu_br_taken}.
  - dir_mp = ckpt[rptr] != exu_br_taken.
  - mp = dir_mp | exu_br_tgt_mp.
- exu_br_valid with FIFO empty: no state change except ghr_err <= 1 for one cycle.
- recover = (pop_en & mp) | exu_flush.
- Mispredict (pop_en & mp, no flush):
  - fghr <= {rghr[GHR_SIZE-2:0], exu_br_taken}, i.e. the new rghr.
  - All younger entries discarded: wptr <= rptr+1, count <= 0.
  - A same-cycle push is dropped.
  - ghr_mispredict <= 1 next cycle.
- exu_flush:
  - fghr <= rghr_next, where rghr_next includes any same-cycle resolve.
  - FIFO cleared; same-cycle push dropped.
  - ghr_mispredict <= 1 only if a same-cycle resolve mispredicted.
- Correctly predicted resolve: fghr follows the push rule only.
- Push + correct pop in the same cycle: count unchanged, both pointers advance.
- Count update: count_next = count + push_en - pop_en; held in CKPT_PTR_W+1 bits.
  - ghr_ckpt_full = (count == CKPT_DEPTH).
  - ghr_ckpt_empty = (count == 0).
- Latency: every output changes only on a clock edge; fghr reflects a push or recovery one cycle after the event.
- Invariant (assertion): after any recovery, fghr == rghr until the next push.

Decomposition:
- Shared package el2_bp_pkg:
  - typedef el2_ghr_ckpt_t (predicted direction bit; reserved field for future target checkpoint).
  - localparam for default GHR_SIZE, consistent with BHT_GHR_SIZE.
- One sub-module: el2_bp_ghr_ckpt_fifo.
  - Parameterised depth; push/pop/clear.
  - Outputs: head data, count, full, empty.
  - Top module holds the fghr/rghr shifters and recovery muxing.

Test Plan (GHR_SIZE=8, CKPT_DEPTH=4):
- Reset then push T,N,T → fghr = 8'h05, rghr = 8'h00, count = 3; resolve T,N,T correctly → rghr = 8'h05, ghr_ckpt_empty = 1, no ghr_mispredict pulse.
- Push T,T,T,T → ghr_ckpt_full = 1. A 5th ifu_bp_valid is not accepted and fghr stays 8'h0F. A resolve (T) with a simultaneous push: push dropped that cycle, count = 3; the retried push is accepted the next cycle.
- Push T,T,N, resolve first as N → fghr = 8'h00, rghr = 8'h00, count = 0, ghr_mispredict pulses one cycle later; a same-cycle push is ignored.
- Correct-direction resolve with exu_br_tgt_mp = 1 → FIFO cleared, fghr = new rghr, ghr_mispredict pulses.
- Push 3 branches, assert exu_flush together with a correct resolve T → rghr = 8'h01, fghr = 8'h01, FIFO empty, no ghr_mispredict.
- exu_br_valid with FIFO empty → ghr_err pulses one cycle, fghr/rghr unchanged. Then assert rst asynchronously mid-stream with 2 entries → all outputs return to reset values immediately.

Source files
------------

// File: rtl/el2_bp_pkg.sv
// Shared branch-predictor definitions.
// Contents:
//   BHT_GHR_SIZE     - global history width shared with the BHT index hash
//   el2_ghr_ckpt_t   - one checkpoint FIFO entry (predicted direction plus a
//                      reserved bit kept for a future target checkpoint)
package el2_bp_pkg;

    localparam int BHT_GHR_SIZE = 8;

    typedef struct packed {
        logic tgt_rsvd;  // reserved, always written as 0 today
        logic taken;     // predicted direction at fetch
    } el2_ghr_ckpt_t;

endpackage

// File: rtl/el2_bp_ghr_ckpt_fifo.sv
// In-order checkpoint FIFO for in-flight predicted branches.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   push, wdata   - append one entry (ignored when full or clearing)
//   pop           - retire the head entry (ignored when empty)
//   clear         - drop every entry; a same-cycle pop still advances the
//                   read pointer so both pointers line up afterwards
//   head          - entry at the read pointer
//   count         - number of valid entries (0..DEPTH)
//   full, empty   - count == DEPTH / count == 0
module el2_bp_ghr_ckpt_fifo
    import el2_bp_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  el2_ghr_ckpt_t wdata,
    input  logic          pop,
    input  logic          clear,
    output el2_ghr_ckpt_t head,
    output logic [PTR_W:0] count,
    output logic          full,
    output logic          empty
);

    el2_ghr_ckpt_t    mem [DEPTH];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr];

    assign rptr_next = rptr + (do_pop ? PTR_W'(1) : PTR_W'(0));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, whatever the block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            rptr <= rptr_next;
            if (clear) begin
                wptr  <= rptr_next;
                count <= '0;
            end else begin
                if (do_push) begin
                    wptr <= wptr + PTR_W'(1);
                end
                count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // read while count says it is valid, so resetting it would buy nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/el2_bp_ghr_ctrl.sv
// Global history register control for the branch predictor.
// Keeps a speculative history (fghr, shifted at fetch on each accepted
// prediction) and a retired history (rghr, shifted at resolution). A
// checkpoint FIFO holds the predicted direction of each in-flight branch so
// a resolve can detect a direction mispredict; on mispredict or flush fghr
// is rebuilt from the retired history.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   ifu_bp_valid, ifu_bp_taken  - predicted branch from fetch
//   exu_br_valid, exu_br_taken  - oldest branch resolves, actual direction
//   exu_br_tgt_mp               - resolving branch had a target mispredict
//   exu_flush                   - non-branch pipeline flush
//   fghr, rghr                  - speculative / retired history
//   ghr_ckpt_full/empty         - checkpoint FIFO status
//   ghr_mispredict              - registered pulse, mispredict resolved
//   ghr_err                     - registered pulse, resolve with no branch
module el2_bp_ghr_ctrl
    import el2_bp_pkg::*;
#(
    parameter int  GHR_SIZE   = BHT_GHR_SIZE,
    parameter int  CKPT_DEPTH = 4,
    localparam int CKPT_PTR_W = $clog2(CKPT_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_bp_valid,
    input  logic                ifu_bp_taken,
    input  logic                exu_br_valid,
    input  logic                exu_br_taken,
    input  logic                exu_br_tgt_mp,
    input  logic                exu_flush,
    output logic [GHR_SIZE-1:0] fghr,
    output logic [GHR_SIZE-1:0] rghr,
    output logic                ghr_ckpt_full,
    output logic                ghr_ckpt_empty,
    output logic                ghr_mispredict,
    output logic                ghr_err
);

    el2_ghr_ckpt_t       ckpt_head;
    el2_ghr_ckpt_t       ckpt_wdata;
    logic [CKPT_PTR_W:0] ckpt_count;
    logic                push_en;
    logic                pop_en;
    logic                mp;
    logic                recover;
    logic [GHR_SIZE-1:0] rghr_next;
    logic [GHR_SIZE-1:0] fghr_next;

    assign pop_en  = exu_br_valid & ~ghr_ckpt_empty;
    assign mp      = (ckpt_head.taken != exu_br_taken) | exu_br_tgt_mp;
    assign recover = (pop_en & mp) | exu_flush;
    // A push is refused while full even if a pop frees a slot this cycle,
    // which keeps the full flag off the pop timing path.
    assign push_en = ifu_bp_valid & ~ghr_ckpt_full & ~recover;

    assign ckpt_wdata = '{tgt_rsvd: 1'b0, taken: ifu_bp_taken};

    el2_bp_ghr_ckpt_fifo #(
        .DEPTH (CKPT_DEPTH)
    ) u_ckpt_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_en),
        .wdata (ckpt_wdata),
        .pop   (pop_en),
        .clear (recover),
        .head  (ckpt_head),
        .count (ckpt_count),
        .full  (ghr_ckpt_full),
        .empty (ghr_ckpt_empty)
    );

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        rghr_next = rghr;
        fghr_next = fghr;
        if (pop_en) begin
            rghr_next = {rghr[GHR_SIZE-2:0], exu_br_taken};
        end
        // Recovery restarts speculation from the retired history including
        // the branch resolving now; that covers both mispredict and flush.
        if (recover) begin
            fghr_next = rghr_next;
        end else if (push_en) begin
            fghr_next = {fghr[GHR_SIZE-2:0], ifu_bp_taken};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fghr           <= '0;
            rghr           <= '0;
            ghr_mispredict <= 1'b0;
            ghr_err        <= 1'b0;
        end else begin
            fghr           <= fghr_next;
            rghr           <= rghr_next;
            ghr_mispredict <= pop_en & mp;
            ghr_err        <= exu_br_valid & ghr_ckpt_empty;
        end
    end

    // After a recovery the histories agree, and they stay equal until fetch
    // pushes again (the FIFO is empty, so nothing can resolve meanwhile).
    a_recover_sync : assert property (@(posedge clk) disable iff (rst)
        recover |=> (fghr == rghr));
    a_hold_sync : assert property (@(posedge clk) disable iff (rst)
        (ghr_ckpt_empty && (fghr == rghr) && !push_en) |=> (fghr == rghr));
    a_count_range : assert property (@(posedge clk) disable iff (rst)
        ckpt_count <= (CKPT_PTR_W+1)'(CKPT_DEPTH));
    a_rsvd_zero : assert property (@(posedge clk) disable iff (rst)
        !ghr_ckpt_empty |-> !ckpt_head.tgt_rsvd);

endmodule
